// File: rtl/fir_stream_feeder_if.sv
// Host byte port and FIR-side drive lines of the stream feeder.
// The slave modport is the feeder's view; the master modport drives bytes and observes the filter side.
interface fir_stream_feeder_if #(
    parameter int DATA_W = 6
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x_n;
    logic              x_valid;
    logic              set_coeffs;
    logic              coef_done;
    logic              busy;
    logic              err;

    modport master (
        output in_data, in_valid,
        input  in_ready, x_n, x_valid, set_coeffs, coef_done, busy, err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, x_n, x_valid, set_coeffs, coef_done, busy, err
    );
endinterface

// File: rtl/fir_stream_feeder.sv
// Buffers tagged host bytes and paces them onto the FIR x_n/x_valid lines,
// framing coefficient groups with set_coeffs.
//
// state | meaning
// IDLE  | issue samples, drop reserved bytes, coefficient head opens a group
// COEF  | set_coeffs high, issuing coefficient words one per pace slot
// DONE  | last tap issued; next edge drops set_coeffs and pulses coef_done
module fir_stream_feeder #(
    parameter int DATA_W     = 6,
    parameter int NUM_TAPS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PACE       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fir_stream_feeder_if.slave bus
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int PCW = $clog2(PACE + 1);
    localparam int TW  = $clog2(NUM_TAPS + 1);

    typedef enum logic [1:0] {IDLE, COEF, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [PCW-1:0]    r_pace_cnt;
    logic [TW-1:0]     r_tap_cnt;
    logic [TW-1:0]     w_tap_nxt;
    logic [DATA_W-1:0] r_x_n;
    logic              r_x_valid;
    logic              r_set_coeffs;
    logic              r_coef_done;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_err_set;
    logic              w_pace_rdy;
    logic [7:0]        w_head;
    logic [1:0]        w_tag;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_tag      = w_head[7:6];
    assign w_pace_rdy = (r_pace_cnt == '0);

    // No write bypass: a full buffer refuses the byte even on a popping edge.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap_cnt;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    case (w_tag)
                        2'b00: begin
                            w_pop   = w_pace_rdy;
                            w_issue = w_pace_rdy;
                        end
                        2'b01: w_state_nxt = COEF;
                        default: begin
                            w_pop     = 1'b1;
                            w_err_set = 1'b1;
                        end
                    endcase
                end
            end
            COEF: begin
                if (!w_empty) begin
                    case (w_tag)
                        2'b01: begin
                            if (w_pace_rdy) begin
                                w_pop     = 1'b1;
                                w_issue   = 1'b1;
                                w_tap_nxt = r_tap_cnt + TW'(1);
                                if (r_tap_cnt == TW'(NUM_TAPS - 1)) begin
                                    w_state_nxt = DONE;
                                end
                            end
                        end
                        // A sample inside a group aborts it; the sample stays queued for IDLE.
                        2'b00: begin
                            w_err_set   = 1'b1;
                            w_tap_nxt   = '0;
                            w_state_nxt = IDLE;
                        end
                        default: begin
                            w_pop     = 1'b1;
                            w_err_set = 1'b1;
                        end
                    endcase
                end
            end
            DONE: begin
                w_tap_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tap_cnt    <= '0;
            r_pace_cnt   <= '0;
            r_x_n        <= '0;
            r_x_valid    <= 1'b0;
            r_set_coeffs <= 1'b0;
            r_coef_done  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tap_cnt    <= w_tap_nxt;
            r_x_valid    <= w_issue;
            r_set_coeffs <= (w_state_nxt == COEF) || (w_state_nxt == DONE);
            r_coef_done  <= (r_state == DONE);
            r_err        <= r_err | w_err_set;
            if (w_issue) begin
                r_x_n      <= DATA_W'(w_head[5:0]);
                r_pace_cnt <= PCW'(PACE - 1);
            end else if (!w_pace_rdy) begin
                r_pace_cnt <= r_pace_cnt - PCW'(1);
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.x_n        = r_x_n;
    assign bus.x_valid    = r_x_valid;
    assign bus.set_coeffs = r_set_coeffs;
    assign bus.coef_done  = r_coef_done;
    assign bus.busy       = !w_empty || (r_state != IDLE);
    assign bus.err        = r_err;
endmodule

// File: tb/tb_fir_stream_feeder.sv
// Scoreboard bench for fir_stream_feeder: expected strobes are queued as bytes are driven
// and matched as x_valid pulses appear; timing of strobes and coef_done is checked against edges.
module tb_fir_stream_feeder;
   localparam int DATA_W     = 6;
   localparam int NUM_TAPS   = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int PACE       = 4;

   typedef struct packed {
      logic       coef;
      logic [5:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fir_stream_feeder_if #(.DATA_W(DATA_W)) bus ();

   fir_stream_feeder #(
      .DATA_W     (DATA_W),
      .NUM_TAPS   (NUM_TAPS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PACE       (PACE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   exp_t e;
   int   strobe_cyc[$];
   int   done_cyc[$];
   int   n_coef_strobes = 0;
   int   last_coef_cyc  = -10;
   int   rise_cyc       = -10;
   int   last_acc_cyc   = 0;
   logic first_pending  = 1'b0;
   logic prev_setc      = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_setc     = 1'b0;
         first_pending = 1'b0;
      end else begin
         if (bus.set_coeffs && !prev_setc) begin
            rise_cyc      = cyc;
            first_pending = 1'b1;
         end
         prev_setc = bus.set_coeffs;
         if (bus.x_valid) begin
            strobe_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
               chk("unexpected_strobe", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               chk("x_n", bus.x_n, e.data);
               chk("strobe_set_coeffs", bus.set_coeffs, e.coef);
            end
            if (bus.set_coeffs) begin
               n_coef_strobes++;
               last_coef_cyc = cyc;
               if (first_pending) begin
                  chk("coef_lead", cyc, rise_cyc + 1);
                  first_pending = 1'b0;
               end
            end
         end
         if (bus.coef_done) begin
            done_cyc.push_back(cyc);
            chk("done_set_coeffs_low", bus.set_coeffs, 0);
            chk("done_timing", cyc, last_coef_cyc + 1);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      if (b[7:6] == 2'b00) sb_q.push_back('{coef: 1'b0, data: b[5:0]});
      if (b[7:6] == 2'b01) sb_q.push_back('{coef: 1'b1, data: b[5:0]});
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while ((bus.busy || sb_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb_q.size(), 0);
      chk("drain_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_x_n"}, bus.x_n, 0);
      chk({tag, "_x_valid"}, bus.x_valid, 0);
      chk({tag, "_set_coeffs"}, bus.set_coeffs, 0);
      chk({tag, "_coef_done"}, bus.coef_done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_err"}, bus.err, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs(tag);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] coefs [4];
      int         base;
      int         n;
      coefs[0] = 8'h41; coefs[1] = 8'h42; coefs[2] = 8'h43; coefs[3] = 8'h44;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // single sample, minimum latency
      strobe_cyc.delete();
      send(8'h15);
      drain();
      chk("t1_strobes", strobe_cyc.size(), 1);
      if (strobe_cyc.size() >= 1) chk("t1_latency", strobe_cyc[0], last_acc_cyc + 1);

      // back-to-back samples fill the buffer and are paced
      strobe_cyc.delete();
      for (int i = 1; i <= 5; i++) send(8'(i));
      chk("t2_full_in_ready", bus.in_ready, 0);
      drain();
      chk("t2_strobes", strobe_cyc.size(), 5);
      for (int i = 1; i < strobe_cyc.size(); i++)
         chk("t2_pace_gap", strobe_cyc[i] - strobe_cyc[i-1], PACE);

      // full coefficient group followed by a sample
      strobe_cyc.delete();
      done_cyc.delete();
      for (int i = 0; i < NUM_TAPS; i++) send(coefs[i]);
      send(8'h07);
      drain();
      chk("t3_strobes", strobe_cyc.size(), 5);
      chk("t3_coef_done_count", done_cyc.size(), 1);
      if (strobe_cyc.size() >= 2) chk("t3_coef_gap", strobe_cyc[1] - strobe_cyc[0], PACE);
      chk("t3_err", bus.err, 0);

      // group aborted by a sample
      strobe_cyc.delete();
      done_cyc.delete();
      send(8'h41);
      send(8'h42);
      send(8'h09);
      drain();
      chk("t4_strobes", strobe_cyc.size(), 3);
      chk("t4_coef_done_count", done_cyc.size(), 0);
      chk("t4_err", bus.err, 1);
      chk("t4_set_coeffs", bus.set_coeffs, 0);

      // reserved byte between two samples
      do_reset("t5_reset");
      strobe_cyc.delete();
      send(8'h11);
      send(8'hC0);
      send(8'h12);
      drain();
      chk("t5_strobes", strobe_cyc.size(), 2);
      if (strobe_cyc.size() >= 2) chk("t5_pace_gap", strobe_cyc[1] - strobe_cyc[0], PACE);
      chk("t5_err", bus.err, 1);

      // reset in the middle of a coefficient group
      do_reset("t6_pre");
      base = n_coef_strobes;
      for (int i = 0; i < NUM_TAPS; i++) send(coefs[i]);
      n = 0;
      while (n_coef_strobes < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t6_two_coef_strobes", n_coef_strobes - base, 2);
      chk("t6_mid_group_set_coeffs", bus.set_coeffs, 1);
      do_reset("t6_mid");
      @(negedge clk);
      chk("t6_in_ready_after", bus.in_ready, 1);
      strobe_cyc.delete();
      done_cyc.delete();
      for (int i = 0; i < NUM_TAPS; i++) send(coefs[i]);
      send(8'h07);
      drain();
      chk("t6_strobes", strobe_cyc.size(), 5);
      chk("t6_coef_done_count", done_cyc.size(), 1);
      chk("t6_err", bus.err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
